// File: rtl/reg_dump_scanner_pkg.sv
// Shared types and constants for the register dump scanner.
package reg_dump_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLatch = 2'd1,
        StShow  = 2'd2,
        StDone  = 2'd3
    } scan_state_e;

    localparam int unsigned BytesPerWord = 4;

    localparam logic [1:0] ByteLaneFirst = 2'd0;
    localparam logic [1:0] ByteLaneLast  = 2'(BytesPerWord - 1);

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
        return word[8*sel +: 8];
    endfunction

endpackage

// File: rtl/reg_dump_scanner_dwell_timer.sv
// Counts display cycles for one byte; term_o flags the final cycle of the dwell.
module reg_dump_scanner_dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic term_o
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(DWELL - 1);

    logic [CntW-1:0] count_q, count_d;

    assign term_o = (count_q == TermCnt);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = term_o ? '0 : count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_dump_scanner.sv
// Sweeps the register file through read port A, showing each word a byte at a time on the LEDs.
module reg_dump_scanner
    import reg_dump_scanner_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEDSIZE   = 8,
    parameter int unsigned LAST_ADDR = 31,
    parameter int unsigned DWELL     = 4
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Hold,
    input  logic [DATA_W-1:0]  R_Data,
    output logic [ADDR_W-1:0]  R_Addr,
    output logic [LEDSIZE-1:0] LED,
    output logic [1:0]         Byte_Sel,
    output logic               Busy,
    output logic               Done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              tmr_en, tmr_clr, tmr_term;

    reg_dump_scanner_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk_i  (clk),
        .rst_i  (Reset),
        .en_i   (tmr_en),
        .clr_i  (tmr_clr),
        .term_o (tmr_term)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        tmr_en  = 1'b0;
        tmr_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StLatch;
                    addr_d  = '0;
                end
            end
            StLatch: begin
                // Snapshot decouples the display from writes landing during SHOW.
                snap_d  = R_Data;
                sel_d   = ByteLaneFirst;
                tmr_clr = 1'b1;
                state_d = StShow;
            end
            StShow: begin
                if (!Hold) begin
                    tmr_en = 1'b1;
                    if (tmr_term) begin
                        if (sel_q != ByteLaneLast) begin
                            sel_d = sel_q + 2'd1;
                        end else if (addr_q < LastAddr) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StLatch;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = '0;
                sel_d   = ByteLaneFirst;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sel_q   <= ByteLaneFirst;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        LED = '0;
        if (state_q == StShow) begin
            LED = LEDSIZE'(byte_lane(snap_q, sel_q));
        end
    end

    assign R_Addr   = addr_q;
    assign Byte_Sel = sel_q;
    assign Busy     = (state_q == StLatch) || (state_q == StShow);
    assign Done     = (state_q == StDone);

endmodule
